// File: rtl/vecmul_pkg.sv
// Shared widths, saturation constant and narrowed-word layout for the vector multiplier datapath.
// Latency: none (declarations only).
// Backpressure: not applicable.
package vecmul_pkg;

    localparam int VEC_IN_W  = 18;
    localparam int VEC_ACC_W = 32;

    localparam logic [VEC_IN_W-1:0] SAT_MAX18 = 18'h3FFFF;

    // One buffered output word: saturation flag above the narrowed data.
    typedef struct packed {
        logic                sat;
        logic [VEC_IN_W-1:0] data;
    } narrow_word_t;

endpackage

// File: rtl/narrow_fifo2.sv
// Generic 2-entry synchronous FIFO with occupancy count and registered head output.
// Latency: a push into an empty FIFO is visible on head_dat the next cycle.
// Backpressure: push ignored when full, pop ignored when empty; caller derives ready/valid from count.
module narrow_fifo2 #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_head_dat,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem0;   // head entry
    logic [W-1:0] r_mem1;   // entry behind the head
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_push = i_push && (r_count != 2'd2);
    assign w_pop  = i_pop  && (r_count != 2'd0);

    // Storage shifts toward the head so the head register only changes on a pop or a push into empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_count <= 2'd0;
        end else begin
            if (w_pop && (r_count == 2'd2)) begin
                r_mem0 <= r_mem1;
            end else if (w_pop && w_push) begin
                r_mem0 <= i_push_dat;
            end else if (w_push && (r_count == 2'd0)) begin
                r_mem0 <= i_push_dat;
            end else if (w_push && !w_pop && (r_count == 2'd1)) begin
                r_mem1 <= i_push_dat;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_head_dat = r_mem0;
    assign o_count    = r_count;

endmodule

// File: rtl/binary_narrowing.sv
// Narrows unsigned accumulator words to operand width with saturation flag and saturation statistics.
// Latency: 1 cycle from accept to out_valid when the buffer is empty; 1 word/cycle sustained.
// Backpressure: 2-entry buffer; in_ready drops only when both entries hold unpopped words, never from in_valid/out_ready.
module binary_narrowing
    import vecmul_pkg::*;
#(
    parameter int IN_W  = VEC_ACC_W,
    parameter int OUT_W = VEC_IN_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] sat_count,
    output logic             sat_sticky
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             w_accept;
    logic             w_pop;
    logic             w_hi_nz;
    logic [OUT_W:0]   w_push_word;
    logic [OUT_W:0]   w_head_word;
    logic [1:0]       w_count;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] r_sat_count;
    logic             r_sat_sticky;

    // Ready/valid come straight from the registered occupancy.
    assign in_ready  = (w_count != 2'd2);
    assign out_valid = (w_count != 2'd0);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Any set bit above the output width means the word does not fit.
    assign w_hi_nz     = |in_data[IN_W-1:OUT_W];
    assign w_push_word = w_hi_nz ? {1'b1, {OUT_W{1'b1}}} : {1'b0, in_data[OUT_W-1:0]};

    narrow_fifo2 #(
        .W (OUT_W + 1)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_accept),
        .i_push_dat (w_push_word),
        .i_pop      (w_pop),
        .o_head_dat (w_head_word),
        .o_count    (w_count)
    );

    assign out_data = w_head_word[OUT_W-1:0];
    assign out_sat  = w_head_word[OUT_W];

    // Clear is applied before the increment so a same-cycle saturated accept leaves the count at 1.
    assign w_cnt_base = clear_stats ? '0 : r_sat_count;

    // Saturation statistics: counter sticks at all-ones, sticky flag holds until cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_count  <= '0;
            r_sat_sticky <= 1'b0;
        end else begin
            if (w_accept && w_hi_nz) begin
                r_sat_count  <= (w_cnt_base == CNT_MAX) ? CNT_MAX : w_cnt_base + 1'b1;
                r_sat_sticky <= 1'b1;
            end else begin
                r_sat_count  <= w_cnt_base;
                r_sat_sticky <= r_sat_sticky && !clear_stats;
            end
        end
    end

    assign sat_count  = r_sat_count;
    assign sat_sticky = r_sat_sticky;

endmodule

// File: doc/binary_narrowing.md
# binary_narrowing

- Converts 32-bit unsigned words from the vector-multiplier datapath back to the 18-bit operand width used by the input side.
- Words wider than 18 bits saturate to the 18-bit maximum; a per-word flag marks each saturated word.
- Has valid/ready handshakes on both sides, a 2-entry output buffer and saturation statistics.
- Sits between the multiplier accumulator output and any downstream consumer that takes 18-bit operands.

## Interface
- `IN_W`, 32, input word width
- `OUT_W`, 18, output word width (`OUT_W < IN_W`)
- `CNT_W`, 16, saturation counter width

- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `in_data` in IN_W: unsigned input word
- `in_valid` in 1: `in_data` valid
- `in_ready` out 1: block can accept a word this cycle
- `out_data` out OUT_W: narrowed word
- `out_sat` out 1: the word on `out_data` was saturated
- `out_valid` out 1: `out_data`/`out_sat` valid
- `out_ready` in 1: consumer takes the word this cycle
- `clear_stats` in 1: synchronous clear of `sat_count` and `sat_sticky`
- `sat_count` out CNT_W: number of saturated words accepted; saturates at all-ones
- `sat_sticky` out 1: set on any saturated accept, held until cleared

## Operation
- **Accept:** a word is accepted when `in_valid && in_ready`.
- **Push:** a word is pushed when it is accepted.
- **Pop:** a word is popped when `out_valid && out_ready`.
- **Narrowing:**
  - If `in_data[IN_W-1:OUT_W] == 0`, then `out_data = in_data[OUT_W-1:0]` and `out_sat = 0`.
  - Otherwise `out_data = {OUT_W{1'b1}}` (0x3FFFF) and `out_sat = 1`.
  - The conversion is computed on the accepted word before it is written to the buffer.
- **Buffer:**
  - 2-entry FIFO of `{sat, data}` (OUT_W+1 bits), with an occupancy count of 0..2.
  - `in_ready = (count != 2)`. It depends only on registered state, never on `in_valid`.
  - `out_valid = (count != 0)`. The head entry drives `out_data`/`out_sat`.
  - Push and pop in the same cycle: count unchanged, order preserved. This is legal at count 1, and at count 2 only for the pop, since no push is possible at 2.
  - Holding rule: while `out_valid && !out_ready`, `out_data` and `out_sat` stay stable.
- **Statistics:**
  - On a saturated accept: `sat_count` increments (holds at 2^CNT_W-1) and `sat_sticky` is set.
  - `clear_stats` in the same cycle as a saturated accept: the clear applies first, then the increment. Result: `sat_count = 1`, `sat_sticky = 1`.
  - Without a saturated accept, `clear_stats` gives `sat_count = 0`, `sat_sticky = 0`.
- **Reset:**
  - Buffer count goes to 0, so `out_valid = 0` and `in_ready = 1`.
  - `out_data = 0`, `out_sat = 0`, `sat_count = 0`, `sat_sticky = 0`.
  - Reset asserted mid-stream discards buffered words without popping them. Words presented during reset are not accepted and not counted.

## Timing
- Latency: a word accepted at edge N is on `out_valid`/`out_data` from cycle N+1, when the buffer was empty.
- Throughput: 1 word/cycle sustained while `out_ready` stays high.
- Backpressure: `in_ready` falls in the cycle after the second unpopped push, and rises in the cycle after the pop that frees an entry.
- Statistic outputs update at the edge of the accepting cycle, so they are visible in the same cycle the word appears at the output.
- No combinational path from `in_valid`/`in_data` to any output. No path from `out_ready` to `in_ready`.

## Structure
- Shared package `vecmul_pkg` holds:
  - `VEC_IN_W = 18` and `VEC_ACC_W = 32`
  - `SAT_MAX18 = 18'h3FFFF`
  - typedef `narrow_word_t` = `{logic sat; logic [17:0] data;}`
- Sub-module `narrow_fifo2`: generic 2-entry synchronous FIFO with count, push/pop and head output, parameterised on data width.
- The saturation compare and statistics stay in `binary_narrowing`.

## Test plan
1. **Passthrough.** Push 0x00012345 with `out_ready = 1`. Expect `out_data = 0x12345` and `out_sat = 0` one cycle later; `sat_count` stays 0.
2. **Saturation boundary.** Push 0x0003FFFF, then 0x00040000, then 0xFFFFFFFF. Expect outputs 0x3FFFF/sat 0, 0x3FFFF/sat 1, 0x3FFFF/sat 1; `sat_count = 2`, `sat_sticky = 1`.
3. **Backpressure.** Hold `out_ready = 0` and push 3 words back-to-back. Expect:
   - the first two are accepted and `in_ready = 0` from the cycle after the second;
   - the third stays pending;
   - on raising `out_ready`, words drain in order, then the third is accepted with no loss or duplication.
4. **Simultaneous clear and saturate.** Preload `sat_count = 5`, then assert `clear_stats` together with an accepted 0x00100000. Expect `sat_count = 1` and `sat_sticky = 1`.
5. **Counter ceiling.** With `CNT_W = 4`, push 20 saturating words. Expect `sat_count` to stop at 15.
6. **Reset mid-operation.** With 2 words buffered, assert `rst` for 1 cycle. Expect next cycle `out_valid = 0`, `in_ready = 1`, `sat_count = 0`, and no buffered word is ever emitted.
